// File: rtl/dct_seq_pkg.sv
// Shared types, default parameters and flat-vector helpers for the DCT row sequencer.
package dct_seq_pkg;

    localparam int DEF_N_POINTS = 8;
    localparam int DEF_IN_W     = 16;
    localparam int DEF_OUT_W    = 32;
    localparam int DEF_TIMEOUT  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } seq_state_e;

    // Bit offset of element idx inside a flat vector of width-bit elements.
    function automatic int elem_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dct_seq_timer.sv
// Watchdog counter for the WAIT state; expire_o flags the last permitted cycle.
module dct_seq_timer
    import dct_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/dct_row_sequencer.sv
// Collects an input vector, hands it to the 1-D DCT core and captures the result,
// with busy/done status, sticky error flags and a watchdog on the result phase.
module dct_row_sequencer
    import dct_seq_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    localparam int IDX_W   = $clog2(N_POINTS)
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [IN_W-1:0]            wr_data,
    input  logic                       start,
    input  logic                       clr,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [OUT_W-1:0]           rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err_busy,
    output logic                       err_timeout,
    output logic                       core_in_valid,
    input  logic                       core_in_ready,
    output logic [N_POINTS*IN_W-1:0]   core_in_data,
    input  logic                       core_out_valid,
    output logic                       core_out_ready,
    input  logic [N_POINTS*OUT_W-1:0]  core_out_data
);

    seq_state_e state_q, state_d;

    logic [N_POINTS-1:0][IN_W-1:0]  in_buf_q, in_buf_d;
    logic [N_POINTS-1:0][OUT_W-1:0] res_buf_q, res_buf_d;
    logic [OUT_W-1:0]               rd_data_q;
    logic                           done_q, done_d;
    logic                           err_busy_q, err_busy_d;
    logic                           err_to_q, err_to_d;
    logic                           tmr_expire;

    dct_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .clr_i    (state_q != WAIT),
        .en_i     (state_q == WAIT),
        .expire_o (tmr_expire)
    );

    // clr is applied first so any same-cycle set event below overrides it.
    always_comb begin
        state_d    = state_q;
        in_buf_d   = in_buf_q;
        res_buf_d  = res_buf_q;
        done_d     = done_q;
        err_busy_d = err_busy_q;
        err_to_d   = err_to_q;

        if (clr) begin
            done_d     = 1'b0;
            err_busy_d = 1'b0;
            err_to_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    in_buf_d[wr_idx] = wr_data;
                end
                if (start) begin
                    state_d = LAUNCH;
                    done_d  = 1'b0;
                end
            end
            LAUNCH: begin
                if (start || wr_en) begin
                    err_busy_d = 1'b1;
                end
                if (core_in_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (start || wr_en) begin
                    err_busy_d = 1'b1;
                end
                if (core_out_valid) begin
                    for (int k = 0; k < N_POINTS; k++) begin
                        res_buf_d[k] = core_out_data[elem_lsb(k, OUT_W) +: OUT_W];
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_expire) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            in_buf_q   <= '0;
            res_buf_q  <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_busy_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_buf_q   <= in_buf_d;
            res_buf_q  <= res_buf_d;
            rd_data_q  <= res_buf_q[rd_idx];
            done_q     <= done_d;
            err_busy_q <= err_busy_d;
            err_to_q   <= err_to_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign core_in_valid  = (state_q == LAUNCH);
    assign core_out_ready = (state_q == WAIT);
    assign core_in_data   = in_buf_q;
    assign rd_data        = rd_data_q;
    assign done           = done_q;
    assign err_busy       = err_busy_q;
    assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_dct_row_sequencer.sv
// Directed bench for dct_row_sequencer: transform, backpressure, busy abuse,
// watchdog, corner coincidences and asynchronous mid-operation reset.
module tb_dct_row_sequencer;

    logic         ACLK;
    logic         ARESETN;
    logic         wr_en;
    logic [2:0]   wr_idx;
    logic [15:0]  wr_data;
    logic         start;
    logic         clr;
    logic [2:0]   rd_idx;
    logic [31:0]  rd_data;
    logic         busy;
    logic         done;
    logic         err_busy;
    logic         err_timeout;
    logic         core_in_valid;
    logic         core_in_ready;
    logic [127:0] core_in_data;
    logic         core_out_valid;
    logic         core_out_ready;
    logic [255:0] core_out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] exp_in;
    logic [255:0] out_vec;

    dct_row_sequencer dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_data        (wr_data),
        .start          (start),
        .clr            (clr),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .err_busy       (err_busy),
        .err_timeout    (err_timeout),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_in_data   (core_in_data),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .core_out_data  (core_out_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETN = 1'b0; wr_en = 0; wr_idx = 0; wr_data = 0; start = 0; clr = 0;
        rd_idx = 0; core_in_ready = 0; core_out_valid = 0; core_out_data = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_busy", err_busy, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_in_valid", core_in_valid, 0);
        chk("rst_out_ready", core_out_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_in_data", core_in_data, 0);
        ARESETN = 1'b1;
        tick();

        // basic transform: samples 1..8, core returns 2*in after L=3
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_idx = 3'(i); wr_data = 16'(i + 1);
            tick();
        end
        wr_en = 0;
        exp_in = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        for (int k = 0; k < 8; k++) out_vec[k*32 +: 32] = 32'(2 * (k + 1));
        core_in_ready = 1;
        start = 1; tick(); start = 0;
        chk("basic_in_valid", core_in_valid, 1);
        chk("basic_busy", busy, 1);
        chk("basic_in_data", core_in_data, exp_in);
        tick();
        chk("basic_out_ready", core_out_ready, 1);
        chk("basic_in_valid_drop", core_in_valid, 0);
        tick(); tick();
        core_out_valid = 1; core_out_data = out_vec;
        chk("basic_done_early", done, 0);
        tick();
        core_out_valid = 0;
        chk("basic_done", done, 1);
        chk("basic_busy_clear", busy, 0);
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            tick();
            chk($sformatf("basic_rd%0d", k), rd_data, 128'(2 * (k + 1)));
        end

        // backpressure: ready low for 10 cycles
        core_in_ready = 0;
        start = 1; tick(); start = 0;
        chk("bp_done_cleared", done, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", core_in_valid, 1);
            chk("bp_data", core_in_data, exp_in);
            chk("bp_out_ready", core_out_ready, 0);
            tick();
        end
        core_in_ready = 1;
        tick();
        chk("bp_wait", core_out_ready, 1);

        // busy abuse in WAIT
        start = 1; wr_en = 1; wr_idx = 0; wr_data = 16'h7FFF;
        tick();
        start = 0; wr_en = 0;
        chk("abuse_err_busy", err_busy, 1);
        for (int k = 0; k < 8; k++) out_vec[k*32 +: 32] = 32'(100 + k);
        core_out_valid = 1; core_out_data = out_vec;
        tick();
        core_out_valid = 0;
        chk("abuse_done", done, 1);

        // watchdog: launch and never return a result
        start = 1; tick(); start = 0;
        chk("abuse_relaunch_data", core_in_data, exp_in);
        tick();
        for (int i = 0; i < 63; i++) tick();
        chk("wd_err_early", err_timeout, 0);
        chk("wd_busy_early", busy, 1);
        tick();
        chk("wd_err", err_timeout, 1);
        chk("wd_busy", busy, 0);
        chk("wd_done", done, 0);
        rd_idx = 2;
        tick();
        chk("wd_rd_prior", rd_data, 128'd102);
        clr = 1; tick(); clr = 0;
        chk("clr_err_busy", err_busy, 0);
        chk("clr_err_to", err_timeout, 0);

        // same-cycle write and start
        wr_en = 1; wr_idx = 3; wr_data = 16'hABCD; start = 1;
        tick();
        wr_en = 0; start = 0;
        chk("c1_data", core_in_data, 128'h0008_0007_0006_0005_ABCD_0003_0002_0001);
        chk("c1_err_busy", err_busy, 0);
        tick();
        // result on the timeout cycle
        for (int i = 0; i < 63; i++) tick();
        for (int k = 0; k < 8; k++) out_vec[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
        core_out_valid = 1; core_out_data = out_vec;
        tick();
        core_out_valid = 0;
        chk("c2_done", done, 1);
        chk("c2_err_to", err_timeout, 0);
        rd_idx = 7;
        tick();
        chk("c2_rd7", rd_data, 128'hC0DE_0007);

        // clr coinciding with capture
        start = 1; tick(); start = 0;
        tick();
        core_out_valid = 1; clr = 1;
        tick();
        core_out_valid = 0; clr = 0;
        chk("c3_done", done, 1);

        // asynchronous reset during LAUNCH
        core_in_ready = 0;
        start = 1; tick(); start = 0;
        chk("mr_valid_before", core_in_valid, 1);
        #3 ARESETN = 0;
        #1;
        chk("mr_valid", core_in_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_rd", rd_data, 0);
        chk("mr_in_data", core_in_data, 0);
        tick();
        ARESETN = 1;
        tick();
        wr_en = 1; wr_idx = 5; wr_data = 16'h1234;
        tick();
        wr_en = 0;
        core_in_ready = 1;
        start = 1; tick(); start = 0;
        chk("mr_new_data", core_in_data, 128'h0000_0000_1234_0000_0000_0000_0000_0000);
        tick();
        for (int k = 0; k < 8; k++) out_vec[k*32 +: 32] = 32'hFFFF_FFF0 + 32'(k);
        core_out_valid = 1; core_out_data = out_vec;
        tick();
        core_out_valid = 0;
        chk("mr_new_done", done, 1);
        rd_idx = 5;
        tick();
        chk("mr_new_rd5", rd_data, 128'hFFFF_FFF5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
